// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch.
//  - sw_state_e : controller state, encoded IDLE=0, RUN=1, PAUSE=2, DONE=3
//  - bcd_t      : one BCD digit
//  - mmss_t     : four-digit count {min_tens, min_units, sec_tens, sec_units}
//  - SEG_BLANK  : active-low pattern with every segment off
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_t;
    bcd_t min_u;
    bcd_t sec_t;
    bcd_t sec_u;
  } mmss_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic bcd_t bcd_clamp(bcd_t d, bcd_t lim);
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment decoder. Non-BCD codes blank the digit.
// Ports:
//  i_bcd   in  4  BCD digit
//  o_seg_n out 7  active-low segments, bit order {g,f,e,d,c,b,a}
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg_n
);

  always_comb begin
    o_seg_n = SEG_BLANK;
    case (i_bcd)
      4'd0: o_seg_n = 7'h40;
      4'd1: o_seg_n = 7'h79;
      4'd2: o_seg_n = 7'h24;
      4'd3: o_seg_n = 7'h30;
      4'd4: o_seg_n = 7'h19;
      4'd5: o_seg_n = 7'h12;
      4'd6: o_seg_n = 7'h02;
      4'd7: o_seg_n = 7'h78;
      4'd8: o_seg_n = 7'h00;
      4'd9: o_seg_n = 7'h10;
      default: o_seg_n = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_bcd_ctrl.sv
// MM:SS BCD stopwatch / countdown timer with start/stop and clear buttons.
// Counting is driven by a clock-enable tick from an internal prescaler; no derived clocks.
// Optional feature macro: STOPWATCH_LAP_HOLD_EN (lap button freezes the display).
// Ports:
//  clk, rst                 clock, synchronous active-high reset
//  btn_start_stop           rising edge starts / pauses / resumes
//  btn_clear                rising edge returns to IDLE and reloads the count
//  btn_lap                  rising edge toggles display hold (macro builds only)
//  dir_down                 count direction, latched on clear
//  preset_min/sec_bcd       countdown start value, clamped on load
//  digit_bcd                displayed value {min_tens,min_units,sec_tens,sec_units}
//  seg1..seg4               active-low segments, seg1 = sec units .. seg4 = min tens
//  state                    IDLE=0, RUN=1, PAUSE=2, DONE=3
//  led                      toggles on each tick in RUN
//  done_pulse, wrap_pulse   one-cycle event flags
//  lap_active               display hold in effect
module stopwatch_bcd_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  input  logic        btn_lap,
  input  logic        dir_down,
  input  logic [7:0]  preset_min_bcd,
  input  logic [7:0]  preset_sec_bcd,
  output logic [15:0] digit_bcd,
  output logic [6:0]  seg1,
  output logic [6:0]  seg2,
  output logic [6:0]  seg3,
  output logic [6:0]  seg4,
  output logic [1:0]  state,
  output logic        led,
  output logic        done_pulse,
  output logic        wrap_pulse,
  output logic        lap_active
);

  localparam int unsigned TickDiv = CLK_HZ / TICK_HZ;
  localparam int unsigned PresW   = $clog2(TickDiv);
  localparam logic [PresW-1:0] PresMax = PresW'(TickDiv - 1);
  localparam bcd_t MaxMinT = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MaxMinU = bcd_t'(MAX_MIN % 10);

  sw_state_e        r_state;
  logic [PresW-1:0] r_presc;
  mmss_t            r_cnt;
  logic             r_dir;
  logic             r_led;
  logic             r_done;
  logic             r_wrap;
  logic             r_start_q;
  logic             r_clear_q;

  logic  w_start;
  logic  w_clear;
  logic  w_tick;
  logic  w_go_done;
  logic  w_up_wrap;
  mmss_t w_up;
  mmss_t w_dn;
  mmss_t w_preset;
  mmss_t w_disp;
  logic [6:0] w_preset_min;

  assign w_start = btn_start_stop & ~r_start_q;
  assign w_clear = btn_clear & ~r_clear_q;
  assign w_tick  = (r_state == StRun) && (r_presc == PresMax);

  // Countdown completion, either by a tick reaching zero or by starting at zero.
  assign w_go_done = ~w_clear & r_dir &
                     (((r_state == StIdle) & w_start & (r_cnt == '0)) |
                      ((r_state == StRun) & ~w_start & w_tick & (w_dn == '0)));

  // Up step with BCD carry; wraps to 00:00 after MAX_MIN:59.
  always_comb begin
    w_up      = r_cnt;
    w_up_wrap = 1'b0;
    if (r_cnt.min_t == MaxMinT && r_cnt.min_u == MaxMinU &&
        r_cnt.sec_t == 4'd5 && r_cnt.sec_u == 4'd9) begin
      w_up      = '0;
      w_up_wrap = 1'b1;
    end else if (r_cnt.sec_u != 4'd9) begin
      w_up.sec_u = r_cnt.sec_u + 4'd1;
    end else begin
      w_up.sec_u = 4'd0;
      if (r_cnt.sec_t != 4'd5) begin
        w_up.sec_t = r_cnt.sec_t + 4'd1;
      end else begin
        w_up.sec_t = 4'd0;
        if (r_cnt.min_u != 4'd9) begin
          w_up.min_u = r_cnt.min_u + 4'd1;
        end else begin
          w_up.min_u = 4'd0;
          w_up.min_t = r_cnt.min_t + 4'd1;
        end
      end
    end
  end

  // Down step with BCD borrow. 00:00 never steps in RUN (DONE is entered first),
  // but underflow wraps to MAX_MIN:59 to keep the value legal.
  always_comb begin
    w_dn = r_cnt;
    if (r_cnt.sec_u != 4'd0) begin
      w_dn.sec_u = r_cnt.sec_u - 4'd1;
    end else begin
      w_dn.sec_u = 4'd9;
      if (r_cnt.sec_t != 4'd0) begin
        w_dn.sec_t = r_cnt.sec_t - 4'd1;
      end else begin
        w_dn.sec_t = 4'd5;
        if (r_cnt.min_u != 4'd0) begin
          w_dn.min_u = r_cnt.min_u - 4'd1;
        end else if (r_cnt.min_t != 4'd0) begin
          w_dn.min_u = 4'd9;
          w_dn.min_t = r_cnt.min_t - 4'd1;
        end else begin
          w_dn.min_t = MaxMinT;
          w_dn.min_u = MaxMinU;
        end
      end
    end
  end

  // Preset clamp: digits first, then the minute value against MAX_MIN.
  always_comb begin
    w_preset.min_t = bcd_clamp(preset_min_bcd[7:4], 4'd9);
    w_preset.min_u = bcd_clamp(preset_min_bcd[3:0], 4'd9);
    w_preset.sec_t = bcd_clamp(preset_sec_bcd[7:4], 4'd5);
    w_preset.sec_u = bcd_clamp(preset_sec_bcd[3:0], 4'd9);
    w_preset_min   = 7'(w_preset.min_t) * 7'd10 + 7'(w_preset.min_u);
    if (w_preset_min > 7'(MAX_MIN)) begin
      w_preset.min_t = MaxMinT;
      w_preset.min_u = MaxMinU;
    end
  end

  // Controller: priority clear > start_stop > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_presc   <= '0;
      r_cnt     <= '0;
      r_dir     <= 1'b0;
      r_led     <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_start_q <= 1'b1;
      r_clear_q <= 1'b1;
    end else begin
      r_start_q <= btn_start_stop;
      r_clear_q <= btn_clear;
      r_done    <= w_go_done;
      r_wrap    <= 1'b0;
      if (w_clear) begin
        r_state <= StIdle;
        r_presc <= '0;
        r_led   <= 1'b0;
        r_dir   <= dir_down;
        r_cnt   <= dir_down ? w_preset : '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_start) begin
              r_state <= w_go_done ? StDone : StRun;
              r_presc <= '0;
            end
          end
          StRun: begin
            if (w_start) begin
              r_state <= StPause;
            end else begin
              r_presc <= w_tick ? '0 : r_presc + PresW'(1);
              if (w_tick) begin
                r_led <= ~r_led;
                if (r_dir) begin
                  r_cnt <= w_dn;
                  if (w_go_done) r_state <= StDone;
                end else begin
                  r_cnt  <= w_up;
                  r_wrap <= w_up_wrap;
                end
              end
            end
          end
          StPause: begin
            if (w_start) r_state <= StRun;
          end
          StDone: begin
          end
        endcase
      end
    end
  end

`ifdef STOPWATCH_LAP_HOLD_EN
  logic  r_lap_q;
  logic  r_lap_act;
  mmss_t r_hold;
  logic  w_lap;

  assign w_lap = btn_lap & ~r_lap_q;

  // Hold captures the live count on the setting edge; counting is unaffected.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lap_q   <= 1'b1;
      r_lap_act <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_lap_q <= btn_lap;
      if (w_clear || w_go_done) begin
        r_lap_act <= 1'b0;
      end else if (w_lap && (r_state == StRun || r_state == StPause)) begin
        r_lap_act <= ~r_lap_act;
        if (!r_lap_act) r_hold <= r_cnt;
      end
    end
  end

  assign w_disp     = r_lap_act ? r_hold : r_cnt;
  assign lap_active = r_lap_act;
`else
  logic w_unused_lap;
  assign w_unused_lap = btn_lap;
  assign w_disp       = r_cnt;
  assign lap_active   = 1'b0;
`endif

  assign digit_bcd  = w_disp;
  assign state      = r_state;
  assign led        = r_led;
  assign done_pulse = r_done;
  assign wrap_pulse = r_wrap;

  seg7_decoder u_seg1 (.i_bcd(w_disp.sec_u), .o_seg_n(seg1));
  seg7_decoder u_seg2 (.i_bcd(w_disp.sec_t), .o_seg_n(seg2));
  seg7_decoder u_seg3 (.i_bcd(w_disp.min_u), .o_seg_n(seg3));
  seg7_decoder u_seg4 (.i_bcd(w_disp.min_t), .o_seg_n(seg4));

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// Self-checking bench for stopwatch_bcd_ctrl (CLK_HZ=10, TICK_HZ=1, MAX_MIN=59).
// Expectations are queued with a due cycle when stimulus is driven and compared on the
// falling edge of that cycle.
module tb_stopwatch_bcd_ctrl;

`ifdef STOPWATCH_LAP_HOLD_EN
  localparam bit LapEn = 1'b1;
`else
  localparam bit LapEn = 1'b0;
`endif

  localparam int SelDig   = 0;
  localparam int SelState = 1;
  localparam int SelLed   = 2;
  localparam int SelDone  = 3;
  localparam int SelWrap  = 4;
  localparam int SelLap   = 5;
  localparam int SelSeg1  = 6;
  localparam int SelSeg4  = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start_stop = 1'b1;
  logic        btn_clear = 1'b0;
  logic        btn_lap = 1'b0;
  logic        dir_down = 1'b0;
  logic [7:0]  preset_min_bcd = 8'h00;
  logic [7:0]  preset_sec_bcd = 8'h00;
  logic [15:0] digit_bcd;
  logic [6:0]  seg1, seg2, seg3, seg4;
  logic [1:0]  state;
  logic        led, done_pulse, wrap_pulse, lap_active;

  stopwatch_bcd_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .MAX_MIN(59)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .btn_lap        (btn_lap),
    .dir_down       (dir_down),
    .preset_min_bcd (preset_min_bcd),
    .preset_sec_bcd (preset_sec_bcd),
    .digit_bcd      (digit_bcd),
    .seg1           (seg1),
    .seg2           (seg2),
    .seg3           (seg3),
    .seg4           (seg4),
    .state          (state),
    .led            (led),
    .done_pulse     (done_pulse),
    .wrap_pulse     (wrap_pulse),
    .lap_active     (lap_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(int sel);
    case (sel)
      SelDig:   return digit_bcd;
      SelState: return {14'd0, state};
      SelLed:   return {15'd0, led};
      SelDone:  return {15'd0, done_pulse};
      SelWrap:  return {15'd0, wrap_pulse};
      SelLap:   return {15'd0, lap_active};
      SelSeg1:  return {9'd0, seg1};
      SelSeg4:  return {9'd0, seg4};
      default:  return 16'hxxxx;
    endcase
  endfunction

  // d = 1 means the value visible right after the next sampling clock edge.
  task automatic push(int sel, string tag, logic [15:0] e, int d);
    exp_t x;
    x.due = cyc + d;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].due == cyc) begin
        check_eq(q[i].tag, observe(q[i].sel), q[i].exp);
        q.delete(i);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with start held high: no start command may fire afterwards.
    step(3);
    rst = 1'b0;
    push(SelState, "rst_state", 16'd0, 1);
    push(SelDig,   "rst_digits", 16'h0000, 1);
    push(SelLed,   "rst_led", 16'd0, 1);
    push(SelDone,  "rst_done", 16'd0, 1);
    push(SelWrap,  "rst_wrap", 16'd0, 1);
    push(SelLap,   "rst_lap", 16'd0, 1);
    push(SelSeg1,  "rst_seg1", 16'h0040, 1);
    push(SelState, "held_start_idle", 16'd0, 2);
    step(2);
    btn_start_stop = 1'b0;
    step(1);

    // First tick 10 cycles after start, then run up to 59:59 and wrap.
    btn_start_stop = 1'b1;
    push(SelState, "start_run", 16'd1, 1);
    push(SelDig,   "pre_first_tick", 16'h0000, 10);
    push(SelDig,   "first_tick", 16'h0001, 11);
    push(SelLed,   "first_tick_led", 16'd1, 11);
    push(SelSeg1,  "first_tick_seg1", 16'h0079, 11);
    push(SelDig,   "min_carry", 16'h1000, 6001);
    push(SelDig,   "at_max", 16'h5959, 35991);
    push(SelLed,   "at_max_led", 16'd1, 35991);
    push(SelWrap,  "no_wrap_early", 16'd0, 36000);
    push(SelDig,   "wrap_digits", 16'h0000, 36001);
    push(SelWrap,  "wrap_pulse", 16'd1, 36001);
    push(SelState, "wrap_stay_run", 16'd1, 36001);
    push(SelLed,   "wrap_led", 16'd0, 36001);
    push(SelWrap,  "wrap_one_cycle", 16'd0, 36002);
    push(SelDig,   "after_wrap", 16'h0001, 36011);
    step(1);
    btn_start_stop = 1'b0;
    step(36015);

    // Countdown from 00:02 to DONE.
    dir_down = 1'b1;
    preset_min_bcd = 8'h00;
    preset_sec_bcd = 8'h02;
    btn_clear = 1'b1;
    push(SelState, "clr_idle", 16'd0, 1);
    push(SelDig,   "clr_preset", 16'h0002, 1);
    push(SelLed,   "clr_led", 16'd0, 1);
    step(1);
    btn_clear = 1'b0;
    step(1);
    btn_start_stop = 1'b1;
    push(SelDig,   "dn_hold", 16'h0002, 10);
    push(SelDig,   "dn_first", 16'h0001, 11);
    push(SelState, "dn_still_run", 16'd1, 20);
    push(SelDone,  "dn_no_done", 16'd0, 20);
    push(SelDig,   "dn_zero", 16'h0000, 21);
    push(SelState, "dn_done_state", 16'd3, 21);
    push(SelDone,  "dn_done_pulse", 16'd1, 21);
    push(SelDone,  "dn_done_one", 16'd0, 22);
    step(1);
    btn_start_stop = 1'b0;
    step(24);
    btn_start_stop = 1'b1;
    push(SelState, "done_ign_start", 16'd3, 1);
    push(SelState, "done_stays", 16'd3, 10);
    push(SelDig,   "done_digits", 16'h0000, 10);
    push(SelDone,  "done_no_repulse", 16'd0, 1);
    step(1);
    btn_start_stop = 1'b0;
    step(10);

    // Start in countdown mode at 00:00 goes straight to DONE.
    preset_sec_bcd = 8'h00;
    btn_clear = 1'b1;
    push(SelState, "clr0_idle", 16'd0, 1);
    step(1);
    btn_clear = 1'b0;
    step(1);
    btn_start_stop = 1'b1;
    push(SelState, "zero_start_done", 16'd3, 1);
    push(SelDone,  "zero_start_pulse", 16'd1, 1);
    push(SelDone,  "zero_start_one", 16'd0, 2);
    step(1);
    btn_start_stop = 1'b0;
    step(2);

    // Pause with prescaler at 4, hold 50 cycles, resume.
    dir_down = 1'b0;
    btn_clear = 1'b1;
    push(SelState, "clr_up_idle", 16'd0, 1);
    push(SelDig,   "clr_up_zero", 16'h0000, 1);
    step(1);
    btn_clear = 1'b0;
    step(1);
    btn_start_stop = 1'b1;
    push(SelState, "p_start_run", 16'd1, 1);
    step(1);
    btn_start_stop = 1'b0;
    step(4);
    btn_start_stop = 1'b1;
    push(SelState, "pause_state", 16'd2, 1);
    push(SelState, "pause_hold", 16'd2, 40);
    push(SelDig,   "pause_digits", 16'h0000, 40);
    step(1);
    btn_start_stop = 1'b0;
    step(49);
    btn_start_stop = 1'b1;
    push(SelState, "resume_run", 16'd1, 1);
    push(SelDig,   "resume_no_tick", 16'h0000, 6);
    push(SelDig,   "resume_tick", 16'h0001, 7);
    push(SelDig,   "resume_tick2", 16'h0002, 17);
    step(1);
    btn_start_stop = 1'b0;
    step(17);

    // Clear and start together while running; preset clamps to 59:59.
    dir_down = 1'b1;
    preset_min_bcd = 8'h7A;
    preset_sec_bcd = 8'h9F;
    btn_clear = 1'b1;
    btn_start_stop = 1'b1;
    push(SelState, "clr_wins_state", 16'd0, 1);
    push(SelDig,   "clamp_digits", 16'h5959, 1);
    push(SelSeg4,  "clamp_seg4", 16'h0012, 1);
    push(SelSeg1,  "clamp_seg1", 16'h0010, 1);
    push(SelState, "clr_wins_stays", 16'd0, 8);
    step(1);
    btn_clear = 1'b0;
    btn_start_stop = 1'b0;
    step(8);
    preset_min_bcd = 8'h04;
    preset_sec_bcd = 8'h73;
    btn_clear = 1'b1;
    push(SelDig,   "clamp_sec_tens", 16'h0453, 1);
    step(1);
    btn_clear = 1'b0;
    step(1);

    // Lap hold: frozen display with the macro, live display without it.
    dir_down = 1'b0;
    btn_clear = 1'b1;
    push(SelDig,   "lap_clr", 16'h0000, 1);
    step(1);
    btn_clear = 1'b0;
    step(1);
    btn_start_stop = 1'b1;
    push(SelState, "lap_start", 16'd1, 1);
    push(SelDig,   "lap_at_3", 16'h0003, 31);
    step(1);
    btn_start_stop = 1'b0;
    step(30);
    btn_lap = 1'b1;
    push(SelLap,   "lap_set", LapEn ? 16'd1 : 16'd0, 1);
    push(SelDig,   "lap_mid", LapEn ? 16'h0003 : 16'h0004, 10);
    push(SelDig,   "lap_hold", LapEn ? 16'h0003 : 16'h0005, 20);
    push(SelSeg1,  "lap_hold_seg1", LapEn ? 16'h0030 : 16'h0012, 20);
    step(1);
    btn_lap = 1'b0;
    step(20);
    btn_lap = 1'b1;
    push(SelLap,   "lap_release", 16'd0, 1);
    push(SelDig,   "lap_live", 16'h0005, 1);
    step(1);
    btn_lap = 1'b0;
    step(3);

    for (int i = 0; i < 100 && q.size() != 0; i++) step(1);
    while (q.size() != 0) begin
      check_eq({"unserviced_", q[0].tag}, 16'hdead, q[0].exp);
      void'(q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
